// File: rtl/rv_core_pkg.sv
// Shared definitions for the integer-core writeback path: register address
// width selection, register count and the writeback source tag.
package rv_core_pkg;

    // RV32E exposes 16 architectural registers, RV32I exposes 32.
    function automatic int raddr_w(input bit emb);
        return emb ? 4 : 5;
    endfunction

    // Architectural register count of the full RV32I file.
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set when a load issues and
// cleared when its result is accepted; answers the issue-stage hazard query.
module wb_scoreboard
    import rv_core_pkg::*;
#(
    parameter int RAW = 4,
    localparam int NR = 1 << RAW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           set_en,
    input  logic [RAW-1:0] set_idx,
    input  logic           clr_en,
    input  logic [RAW-1:0] clr_idx,
    input  logic           iss_valid,
    input  logic [RAW-1:0] iss_rs1,
    input  logic [RAW-1:0] iss_rs2,
    input  logic [RAW-1:0] iss_rd,
    output logic [NR-1:0]  pending,
    output logic           hazard
);

    logic [NR-1:0] pending_q;
    logic [NR-1:0] pending_d;

    // Clear first so a same-cycle set on the same register takes precedence.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_idx] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // The destination term stalls a second load to a register still in flight.
    always_comb begin
        hazard = iss_valid & (pending_q[iss_rs1] | pending_q[iss_rs2] | pending_q[iss_rd]);
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writer: ALU-over-LSU arbitration into a one-cycle writeback
// register, plus load scoreboard and pre-commit forwarding for the issue stage.
module regfile_writeback
    import rv_core_pkg::*;
#(
    parameter bit embedded = 1'b1,
    localparam int RAW = raddr_w(embedded),
    localparam int NR = 1 << RAW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           alu_valid,
    input  logic [RAW-1:0] alu_rd,
    input  logic [31:0]    alu_data,
    input  logic           lsu_valid,
    output logic           lsu_ready,
    input  logic [RAW-1:0] lsu_rd,
    input  logic [31:0]    lsu_data,
    input  logic           iss_valid,
    input  logic           iss_load,
    input  logic [RAW-1:0] iss_rd,
    input  logic [RAW-1:0] iss_rs1,
    input  logic [RAW-1:0] iss_rs2,
    input  logic           iss_fire,
    output logic           hazard,
    output logic           rs1_fwd_valid,
    output logic [31:0]    rs1_fwd_data,
    output logic           rs2_fwd_valid,
    output logic [31:0]    rs2_fwd_data,
    output logic [RAW-1:0] RdAddr,
    output logic [31:0]    RdData,
    output logic [NR-1:0]  pending
);

    logic           alu_wr;
    logic           lsu_acc;
    logic           sb_set;
    wb_src_e        wb_src;
    logic [RAW-1:0] rd_addr_q;
    logic [RAW-1:0] rd_addr_d;
    logic [31:0]    rd_data_q;
    logic [31:0]    rd_data_d;

    // An ALU result aimed at x0 is not a write, so it does not block the LSU.
    always_comb begin
        alu_wr    = alu_valid & (alu_rd != '0);
        lsu_ready = rst_n & ~alu_wr;
        lsu_acc   = lsu_valid & lsu_ready;
        sb_set    = iss_fire & iss_load & (iss_rd != '0);
    end

    // Accepted loads to x0 are consumed here and never reach the write port.
    always_comb begin
        wb_src = WB_NONE;
        if (alu_wr) begin
            wb_src = WB_ALU;
        end else if (lsu_acc && (lsu_rd != '0)) begin
            wb_src = WB_LSU;
        end
    end

    always_comb begin
        rd_addr_d = '0;
        rd_data_d = rd_data_q;
        unique case (wb_src)
            WB_ALU: begin
                rd_addr_d = alu_rd;
                rd_data_d = alu_data;
            end
            WB_LSU: begin
                rd_addr_d = lsu_rd;
                rd_data_d = lsu_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    wb_scoreboard #(
        .RAW(RAW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_idx  (iss_rd),
        .clr_en   (lsu_acc),
        .clr_idx  (lsu_rd),
        .iss_valid(iss_valid),
        .iss_rs1  (iss_rs1),
        .iss_rs2  (iss_rs2),
        .iss_rd   (iss_rd),
        .pending  (pending),
        .hazard   (hazard)
    );

    // The value on the write port is not yet readable from the register file.
    always_comb begin
        rs1_fwd_valid = (iss_rs1 != '0) & (iss_rs1 == rd_addr_q);
        rs2_fwd_valid = (iss_rs2 != '0) & (iss_rs2 == rd_addr_q);
        rs1_fwd_data  = rd_data_q;
        rs2_fwd_data  = rd_data_q;
    end

    assign RdAddr = rd_addr_q;
    assign RdData = rd_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios followed by randomized
// traffic compared against a register-level behavioural model.
module tb_regfile_writeback;
    import rv_core_pkg::*;

    localparam bit EMB = 1'b0;
    localparam int RAW = raddr_w(EMB);
    localparam int NR = 1 << RAW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           alu_valid;
    logic [RAW-1:0] alu_rd;
    logic [31:0]    alu_data;
    logic           lsu_valid;
    logic           lsu_ready;
    logic [RAW-1:0] lsu_rd;
    logic [31:0]    lsu_data;
    logic           iss_valid;
    logic           iss_load;
    logic [RAW-1:0] iss_rd;
    logic [RAW-1:0] iss_rs1;
    logic [RAW-1:0] iss_rs2;
    logic           iss_fire;
    logic           hazard;
    logic           rs1_fwd_valid;
    logic [31:0]    rs1_fwd_data;
    logic           rs2_fwd_valid;
    logic [31:0]    rs2_fwd_data;
    logic [RAW-1:0] RdAddr;
    logic [31:0]    RdData;
    logic [NR-1:0]  pending;

    int checks = 0;
    int failures = 0;

    regfile_writeback #(.embedded(EMB)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_load(iss_load), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_fire(iss_fire),
        .hazard(hazard),
        .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
        .RdAddr(RdAddr), .RdData(RdData), .pending(pending)
    );

    always #5 clk = ~clk;

    // Illegal stimulus guard: an ALU write must never target a register awaiting a load.
    always @(posedge clk) begin
        if (rst_n && alu_valid && alu_rd != '0 && pending[alu_rd]) begin
            failures++;
            $display("FAIL alu_write_to_pending rd=%0d pending=%h", alu_rd, pending);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 0; iss_load = 0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0; iss_fire = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        lsu_valid = 1;
        #2;
        checks++; if (RdAddr !== '0) begin failures++; $display("FAIL reset_rdaddr got=%h exp=0", RdAddr); end
        checks++; if (RdData !== 32'h0) begin failures++; $display("FAIL reset_rddata got=%h exp=0", RdData); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL reset_lsu_ready got=%b exp=0", lsu_ready); end
        lsu_valid = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_alu_forward();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
        tick();
        idle();
        iss_valid = 1; iss_rs1 = 3; iss_rs2 = 4;
        #1;
        checks++; if (RdAddr !== 3) begin failures++; $display("FAIL alu_rdaddr got=%0d exp=3", RdAddr); end
        checks++; if (RdData !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_rddata got=%h exp=deadbeef", RdData); end
        checks++; if (rs1_fwd_valid !== 1'b1) begin failures++; $display("FAIL fwd_rs1_valid got=%b exp=1", rs1_fwd_valid); end
        checks++; if (rs1_fwd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL fwd_rs1_data got=%h exp=deadbeef", rs1_fwd_data); end
        checks++; if (rs2_fwd_valid !== 1'b0) begin failures++; $display("FAIL fwd_rs2_valid got=%b exp=0", rs2_fwd_valid); end
        tick();
        checks++; if (RdAddr !== 0) begin failures++; $display("FAIL idle_rdaddr got=%0d exp=0", RdAddr); end
        checks++; if (RdData !== 32'hDEADBEEF) begin failures++; $display("FAIL idle_rddata_hold got=%h exp=deadbeef", RdData); end
        checks++; if (rs1_fwd_valid !== 1'b0) begin failures++; $display("FAIL fwd_after_commit got=%b exp=0", rs1_fwd_valid); end
        idle();
    endtask

    task automatic test_load_hazard();
        iss_valid = 1; iss_load = 1; iss_rd = 5; iss_fire = 1;
        #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL load_issue_hazard got=%b exp=0", hazard); end
        tick();
        idle();
        checks++; if (pending[5] !== 1'b1) begin failures++; $display("FAIL load_pending_set got=%h", pending); end
        for (int c = 1; c <= 3; c++) begin
            iss_valid = 1; iss_rs2 = 5; iss_rd = 6;
            if (c == 3) begin
                lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h12345678;
            end
            #1;
            checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL load_hazard cyc=%0d got=%b exp=1", c, hazard); end
            tick();
        end
        idle();
        iss_valid = 1; iss_rs2 = 5; iss_rd = 6;
        #1;
        checks++; if (pending[5] !== 1'b0) begin failures++; $display("FAIL load_pending_clear got=%h", pending); end
        checks++; if (RdAddr !== 5) begin failures++; $display("FAIL load_rdaddr got=%0d exp=5", RdAddr); end
        checks++; if (RdData !== 32'h12345678) begin failures++; $display("FAIL load_rddata got=%h exp=12345678", RdData); end
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL load_hazard_release got=%b exp=0", hazard); end
        idle();
        tick();
    endtask

    task automatic test_arbitration();
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'hCAFE0004;
        for (int c = 0; c < 2; c++) begin
            alu_valid = 1; alu_rd = 7; alu_data = 32'hA0000000 + c;
            #1;
            checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL arb_lsu_ready cyc=%0d got=%b exp=0", c, lsu_ready); end
            tick();
            checks++; if (RdAddr !== 7) begin failures++; $display("FAIL arb_rdaddr cyc=%0d got=%0d exp=7", c, RdAddr); end
            checks++; if (RdData !== 32'hA0000000 + c) begin failures++; $display("FAIL arb_rddata cyc=%0d got=%h", c, RdData); end
        end
        alu_valid = 0;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL arb_lsu_ready_free got=%b exp=1", lsu_ready); end
        tick();
        idle();
        checks++; if (RdAddr !== 4) begin failures++; $display("FAIL arb_lsu_rdaddr got=%0d exp=4", RdAddr); end
        checks++; if (RdData !== 32'hCAFE0004) begin failures++; $display("FAIL arb_lsu_rddata got=%h exp=cafe0004", RdData); end
    endtask

    task automatic test_x0();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h0BAD0BAD;
        iss_valid = 1; iss_load = 1; iss_rd = 0; iss_fire = 1;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL x0_lsu_ready got=%b exp=1", lsu_ready); end
        tick();
        idle();
        checks++; if (RdAddr !== 0) begin failures++; $display("FAIL x0_rdaddr got=%0d exp=0", RdAddr); end
        checks++; if (RdData !== 32'hCAFE0004) begin failures++; $display("FAIL x0_rddata got=%h exp=cafe0004", RdData); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL x0_pending got=%h exp=0", pending); end
    endtask

    task automatic test_set_wins();
        iss_valid = 1; iss_load = 1; iss_rd = 9; iss_fire = 1;
        tick();
        idle();
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99990009;
        iss_load = 1; iss_rd = 9; iss_fire = 1;
        tick();
        idle();
        checks++; if (pending[9] !== 1'b1) begin failures++; $display("FAIL set_wins_pending got=%h", pending); end
        checks++; if (RdAddr !== 9) begin failures++; $display("FAIL set_wins_rdaddr got=%0d exp=9", RdAddr); end
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99990019;
        tick();
        idle();
        checks++; if (pending !== '0) begin failures++; $display("FAIL set_wins_clear got=%h exp=0", pending); end
    endtask

    task automatic test_async_reset();
        iss_valid = 1; iss_load = 1; iss_rd = 5; iss_fire = 1;
        tick();
        iss_rd = 2;
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22222222;
        tick();
        idle();
        lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h55555555;
        checks++; if (pending !== NR'(32'h24)) begin failures++; $display("FAIL pre_reset_pending got=%h exp=24", pending); end
        checks++; if (RdAddr !== 2) begin failures++; $display("FAIL pre_reset_rdaddr got=%0d exp=2", RdAddr); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (RdAddr !== '0) begin failures++; $display("FAIL async_rdaddr got=%h exp=0", RdAddr); end
        checks++; if (RdData !== 32'h0) begin failures++; $display("FAIL async_rddata got=%h exp=0", RdData); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL async_pending got=%h exp=0", pending); end
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL async_lsu_ready got=%b exp=0", lsu_ready); end
        idle();
        tick();
        rst_n = 1;
        alu_valid = 1; alu_rd = 11; alu_data = 32'h0B0B0B0B;
        tick();
        idle();
        checks++; if (RdAddr !== 11) begin failures++; $display("FAIL post_reset_rdaddr got=%0d exp=11", RdAddr); end
        checks++; if (RdData !== 32'h0B0B0B0B) begin failures++; $display("FAIL post_reset_rddata got=%h", RdData); end
    endtask

    task automatic test_random(input int n);
        logic [NR-1:0]  m_pend;
        logic [RAW-1:0] m_addr;
        logic [31:0]    m_data;
        logic [RAW-1:0] inflight[$];
        bit             offering;
        bit             m_alu_wr;
        bit             m_haz;
        bit             m_acc;
        int             k;

        rst_n = 0;
        idle();
        tick();
        rst_n = 1;
        m_pend = '0; m_addr = '0; m_data = '0; offering = 0;
        for (int cyc = 0; cyc < n; cyc++) begin
            iss_valid = ($urandom % 4) != 0;
            iss_load  = $urandom % 2;
            iss_rd    = RAW'($urandom % NR);
            iss_rs1   = RAW'($urandom % NR);
            iss_rs2   = RAW'($urandom % NR);
            m_haz     = iss_valid && (m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
            iss_fire  = iss_valid && !m_haz && (($urandom % 4) != 0);

            if (!offering && inflight.size() > 0 && ($urandom % 3) == 0) begin
                k = int'($urandom % inflight.size());
                lsu_rd = inflight[k];
                inflight.delete(k);
                lsu_data = $urandom;
                offering = 1;
            end
            lsu_valid = offering;

            alu_valid = $urandom % 2;
            alu_data  = $urandom;
            alu_rd    = RAW'($urandom % NR);
            for (int t = 0; t < 4 && m_pend[alu_rd]; t++) alu_rd = RAW'($urandom % NR);
            if (m_pend[alu_rd]) alu_rd = '0;
            m_alu_wr = alu_valid && (alu_rd != '0);

            #1;
            checks++; if (lsu_ready !== !m_alu_wr) begin failures++; $display("FAIL rnd_lsu_ready cyc=%0d got=%b exp=%b", cyc, lsu_ready, !m_alu_wr); end
            checks++; if (hazard !== m_haz) begin failures++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", cyc, hazard, m_haz); end
            checks++; if (rs1_fwd_valid !== (iss_rs1 != '0 && iss_rs1 == m_addr)) begin failures++; $display("FAIL rnd_fwd1_valid cyc=%0d got=%b", cyc, rs1_fwd_valid); end
            checks++; if (rs2_fwd_valid !== (iss_rs2 != '0 && iss_rs2 == m_addr)) begin failures++; $display("FAIL rnd_fwd2_valid cyc=%0d got=%b", cyc, rs2_fwd_valid); end
            checks++; if (rs1_fwd_data !== m_data || rs2_fwd_data !== m_data) begin failures++; $display("FAIL rnd_fwd_data cyc=%0d got=%h/%h exp=%h", cyc, rs1_fwd_data, rs2_fwd_data, m_data); end

            m_acc = offering && !m_alu_wr;
            if (m_alu_wr) begin
                m_addr = alu_rd; m_data = alu_data;
            end else if (m_acc) begin
                m_addr = lsu_rd; m_data = lsu_data;
            end else begin
                m_addr = '0;
            end
            if (m_acc) begin
                m_pend[lsu_rd] = 1'b0;
                offering = 0;
            end
            if (iss_fire && iss_load && iss_rd != '0) begin
                m_pend[iss_rd] = 1'b1;
                inflight.push_back(iss_rd);
            end

            tick();
            checks++; if (RdAddr !== m_addr) begin failures++; $display("FAIL rnd_rdaddr cyc=%0d got=%0d exp=%0d", cyc, RdAddr, m_addr); end
            checks++; if (RdData !== m_data) begin failures++; $display("FAIL rnd_rddata cyc=%0d got=%h exp=%h", cyc, RdData, m_data); end
            checks++; if (pending !== m_pend) begin failures++; $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", cyc, pending, m_pend); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_hazard();
        test_arbitration();
        test_x0();
        test_set_wins();
        test_async_reset();
        test_random(500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Writer-side controller for the integer register file. It arbitrates single-cycle ALU results against variable-latency load results and registers the winner onto the register file write port (RdAddr/RdData). It keeps a pending-load scoreboard and gives the issue stage hazard and forwarding information. It sits between execute/LSU and the register file in the RV32E/RV32I core.

Parameters:
embedded, 1, 1 = RV32E (16 registers, raddr_w = 4); 0 = RV32I (32 registers, raddr_w = 5)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result present this cycle; no backpressure
alu_rd  in  raddr_w  ALU destination register
alu_data  in  32  ALU result
lsu_valid  in  1  load result offered
lsu_ready  out  1  load result accepted this cycle
lsu_rd  in  raddr_w  load destination register
lsu_data  in  32  load data
iss_valid  in  1  instruction at issue this cycle
iss_load  in  1  issuing instruction is a load
iss_rd  in  raddr_w  issuing instruction destination
iss_rs1  in  raddr_w  issuing instruction source 1
iss_rs2  in  raddr_w  issuing instruction source 2
iss_fire  in  1  issue handshake completed (issue stage drives iss_valid & ~hazard)
hazard  out  1  issue must stall
rs1_fwd_valid  out  1  use rs1_fwd_data instead of the register-file Rs1 value
rs1_fwd_data  out  32  forwarded source 1 value
rs2_fwd_valid  out  1  use rs2_fwd_data instead of the register-file Rs2 value
rs2_fwd_data  out  32  forwarded source 2 value
RdAddr  out  raddr_w  register-file write address; 0 = no write
RdData  out  32  register-file write data
pending  out  2**raddr_w  scoreboard bit per register; bit 0 is always 0

Behaviour:
- Reset (async, rst_n low): RdAddr = 0, RdData = 0, pending = 0, lsu_ready = 0.
  - Takes effect immediately mid-operation; in-flight load results are discarded and not re-requested.
- Arbitration is fixed priority: the ALU wins.
  - ALU write counts only when alu_valid = 1 and alu_rd != 0.
  - lsu_ready = ~(ALU write); combinational, 0 during reset.
  - LSU accepted when lsu_valid & lsu_ready.
  - lsu_rd/lsu_data are held stable by the LSU until accepted.
- Writeback register, latency 1:
  - ALU write → RdAddr = alu_rd, RdData = alu_data.
  - Else LSU accepted → RdAddr = lsu_rd, RdData = lsu_data.
  - Else RdAddr = 0; RdData holds its previous value.
  - The register file commits at the following edge.
- Destination x0: writes with rd = 0 never appear on RdAddr and never set pending.
  - An accepted LSU result with lsu_rd = 0 is consumed and dropped.
- Scoreboard:
  - Set: iss_fire & iss_load & iss_rd != 0 sets pending[iss_rd].
  - Clear: LSU acceptance clears pending[lsu_rd].
  - Same register set and cleared in one cycle → set wins.
- hazard is combinational: iss_valid & (pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd]).
  - The pending[iss_rd] term covers WAW.
- Forwarding (combinational):
  - rsN_fwd_valid = (iss_rsN != 0) & (iss_rsN == RdAddr); rsN_fwd_data = RdData.
  - This covers the one-cycle window before the register-file commit.
- Error condition: ALU write to a register with pending set is illegal. The bench flags it with an assertion; RTL behaviour is unspecified.
- Wrap/overflow: none; the scoreboard is one bit per register. Multiple outstanding loads are allowed if their destinations differ.

Decomposition:
- Package rv_core_pkg:
  - function raddr_w(embedded)
  - constant NUM_REGS
  - typedef wb_src_e {WB_NONE, WB_ALU, WB_LSU}, used for debug/trace
- One sub-module, wb_scoreboard: pending vector, set/clear logic, hazard lookup.

Test Plan:
- ALU alu_valid = 1, alu_rd = 3, alu_data = 0xDEADBEEF at cycle 0 → cycle 1: RdAddr = 3, RdData = 0xDEADBEEF; issue with iss_rs1 = 3 in cycle 1 → rs1_fwd_valid = 1, rs1_fwd_data = 0xDEADBEEF.
- Load issued with iss_rd = 5; lsu_valid = 1, lsu_rd = 5, lsu_data = 0x12345678 three cycles later:
  - pending[5] = 1 after the issue edge.
  - iss_rs2 = 5 → hazard = 1 until acceptance.
  - pending[5] = 0 and RdAddr = 5 one cycle after acceptance.
- lsu_valid and alu_valid (alu_rd = 7) both asserted for 2 cycles → lsu_ready = 0 for both cycles; RdAddr = 7, 7; LSU result written in the first cycle without an ALU write, data unchanged.
- alu_rd = 0 with alu_valid = 1 → lsu_ready = 1, RdAddr = 0; load issue with iss_rd = 0 → pending stays 0.
- Same cycle: accept LSU for x9 and iss_fire load to x9 → pending[9] = 1 after the edge.
- Assert rst_n = 0 with pending = 0x0024 and RdAddr = 2 → all outputs zero immediately, before the next clk edge; normal operation after release.
